// File: rtl/enc_pkg.sv
// Shared widths, FSM state type and output FIFO entry layout for the
// round-robin Hamming-encoder arbiter.
package enc_pkg;

   localparam int NIBBLE_W    = 4;
   localparam int CW_W        = 8;
   localparam int ENC_LAT_DEF = 2;
   // Widest requester id the FIFO entry can carry (up to 256 requesters)
   localparam int ID_MAX_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [CW_W-1:0]     cw;
      logic [ID_MAX_W-1:0] id;
      logic                perr;
   } fifo_entry_t;

endpackage

// File: rtl/enc_out_fifo.sv
// Synchronous FIFO of returned codeword entries; write and pop may coincide at
// any occupancy, and a written entry becomes visible on the following cycle.
module enc_out_fifo
   import enc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en_i,
   input  fifo_entry_t wr_data_i,
   input  logic        rd_en_i,
   output fifo_entry_t rd_data_o,
   output logic        empty_o,
   output logic        full_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_rd;
   logic          do_wr;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign do_rd     = rd_en_i && !empty_o;
   // At full, a same-cycle pop frees the slot the write lands in
   assign do_wr     = wr_en_i && (!full_o || do_rd);
   assign rd_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/enc_arbiter.sv
// Round-robin, credit-gated scheduler feeding one fixed-latency [8,4] encoder.
// Define ENC_ARB_PARITY_CHK_EN to store an overall-parity error flag per entry.
module enc_arbiter
   import enc_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ENC_LAT   = ENC_LAT_DEF,
   parameter int OUT_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [NIBBLE_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic [NIBBLE_W-1:0]       enc_data_o,
   input  logic [CW_W-1:0]           enc_data_i,
   output logic                      out_valid,
   output logic [CW_W-1:0]           out_data,
   output logic [$clog2(N_REQ)-1:0]  out_id,
   output logic                      out_perr,
   input  logic                      out_ready,
   output logic                      busy,
   output logic [1:0]                dbg_state_o
);

   localparam int ID_W   = $clog2(N_REQ);
   localparam int CRED_W = $clog2(OUT_DEPTH + 1);

   // Handshakes: a requester transfers when req_valid & req_ready; the consumer
   // pops when out_valid & out_ready. req_ready never waits on out_ready.
   arb_state_e          state_q, state_d;
   logic [CRED_W-1:0]   credit_q, credit_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [NIBBLE_W-1:0] enc_q, enc_d;
   logic [ENC_LAT:0]    tag_vld_q;
   logic [ID_W-1:0]     tag_id_q [ENC_LAT+1];

   logic                grant_any;
   logic [ID_W-1:0]     grant_id;
   logic [NIBBLE_W-1:0] grant_nib;
   int                  cand;
   logic                pop;
   logic                fifo_wr;
   logic                fifo_empty;
   logic                fifo_full;
   logic                wr_perr;
   fifo_entry_t         wr_entry;
   fifo_entry_t         fifo_head;

   always_comb begin
      req_ready = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = 0;
      if (state_q == RUN && en && credit_q != '0) begin
         for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!grant_any && req_valid[cand]) begin
               grant_any = 1'b1;
               grant_id  = ID_W'(cand);
            end
         end
         req_ready[grant_id] = grant_any;
      end
   end

   assign grant_nib = req_data[grant_id*NIBBLE_W +: NIBBLE_W];
   assign pop       = out_valid && out_ready;
   // Stage 0 travels with enc_data_o; the last stage meets the returning codeword
   assign fifo_wr   = tag_vld_q[ENC_LAT];

   always_comb begin
      credit_d = credit_q;
      ptr_d    = ptr_q;
      enc_d    = '0;
      case ({grant_any, pop})
         2'b10:   credit_d = credit_q - 1'b1;
         2'b01:   credit_d = credit_q + 1'b1;
         default: credit_d = credit_q;
      endcase
      if (grant_any) begin
         enc_d = grant_nib;
         ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en)                              state_d = RUN;
            else if (tag_vld_q == '0 && fifo_empty) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         credit_q  <= CRED_W'(OUT_DEPTH);
         ptr_q     <= '0;
         enc_q     <= '0;
         tag_vld_q <= '0;
         for (int i = 0; i <= ENC_LAT; i++) tag_id_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         ptr_q       <= ptr_d;
         enc_q       <= enc_d;
         tag_vld_q   <= {tag_vld_q[ENC_LAT-1:0], grant_any};
         tag_id_q[0] <= grant_id;
         for (int i = 1; i <= ENC_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
      end
   end

`ifdef ENC_ARB_PARITY_CHK_EN
   assign wr_perr  = ^enc_data_i;
   assign out_perr = fifo_head.perr;
`else
   assign wr_perr  = 1'b0;
   assign out_perr = 1'b0;
`endif

   always_comb begin
      wr_entry      = '0;
      wr_entry.cw   = enc_data_i;
      wr_entry.id   = ID_MAX_W'(tag_id_q[ENC_LAT]);
      wr_entry.perr = wr_perr;
   end

   enc_out_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (fifo_wr),
      .wr_data_i (wr_entry),
      .rd_en_i   (out_ready),
      .rd_data_o (fifo_head),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   assign out_valid   = !fifo_empty;
   assign out_data    = fifo_head.cw;
   assign out_id      = fifo_head.id[ID_W-1:0];
   assign enc_data_o  = enc_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;

   // Credits bound in-flight plus stored entries, so the encoder can never overrun
   always @(posedge clk) begin
      if (rst) begin
         assert (!(fifo_wr && fifo_full));
         assert (credit_q <= CRED_W'(OUT_DEPTH));
         assert ((fifo_head.id >> ID_W) == '0);
`ifndef ENC_ARB_PARITY_CHK_EN
         assert (!fifo_head.perr);
`endif
      end
   end

endmodule

// File: tb/tb_enc_arbiter.sv
// Randomized bench for enc_arbiter with a queue-based reference model and a
// behavioural [8,4] encoder with ENC_LAT cycles of latency.
module tb_enc_arbiter;
   import enc_pkg::*;

   localparam int N_REQ     = 4;
   localparam int ENC_LAT   = 2;
   localparam int OUT_DEPTH = 4;
   localparam int ID_W      = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 en = 1'b0;
   logic [N_REQ-1:0]     req_valid = '0;
   logic [4*N_REQ-1:0]   req_data = '0;
   logic [N_REQ-1:0]     req_ready;
   logic [3:0]           enc_data_o;
   logic [7:0]           enc_data_i = '0;
   logic                 out_valid;
   logic [7:0]           out_data;
   logic [ID_W-1:0]      out_id;
   logic                 out_perr;
   logic                 out_ready = 1'b0;
   logic                 busy;
   logic [1:0]           dbg_state;

   enc_arbiter #(.N_REQ(N_REQ), .ENC_LAT(ENC_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .enc_data_o  (enc_data_o),
      .enc_data_i  (enc_data_i),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_id      (out_id),
      .out_perr    (out_perr),
      .out_ready   (out_ready),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [3:0]      nib;
      int              due;
   } flight_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          dut_grants = 0;
   int          m_state = 0;   // 0 idle, 1 run, 2 drain
   int          m_ptr = 0;
   logic [3:0]  m_enc = '0;
   logic        flip_arm = 1'b0;
   flight_t     fl_q[$];
   logic [10:0] exp_q[$];      // {codeword, id, perr}
   logic [3:0]  enc_hist[$];

   function automatic logic [7:0] ham(input logic [3:0] d);
      logic       p1, p2, p4;
      logic [6:0] c;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      c  = {d[3], d[2], d[1], p4, d[0], p2, p1};
      return {c, ^c};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step();
      int          g;
      logic [31:0] exp_rdy;
      logic [3:0]  nib;
      logic [7:0]  cw;
      logic [10:0] hd;
      logic        perr, quiet, pop, flip_now;
      flight_t     f;
      enc_hist.push_back(enc_data_o);
      if (enc_hist.size() > ENC_LAT + 1) void'(enc_hist.pop_front());
      enc_data_i = (enc_hist.size() == ENC_LAT + 1) ? ham(enc_hist[0]) : 8'h00;
      flip_now = 1'b0;
      if (flip_arm && fl_q.size() != 0 && fl_q[0].due == cyc) begin
         enc_data_i[0] = ~enc_data_i[0];
         flip_now = 1'b1;
         flip_arm = 1'b0;
      end
      #1;
      g = -1;
      if (m_state == 1 && en && (fl_q.size() + exp_q.size()) < OUT_DEPTH) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
         end
      end
      exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
      check("req_ready", 32'(req_ready), exp_rdy);
      check("enc_data_o", 32'(enc_data_o), 32'(m_enc));
      check("busy", 32'(busy), 32'(m_state != 0));
      check("state", 32'(dbg_state), 32'(m_state));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         hd = exp_q[0];
         check("out_data", 32'(out_data), 32'(hd[10:3]));
         check("out_id", 32'(out_id), 32'(hd[2:1]));
         check("out_perr", 32'(out_perr), 32'(hd[0]));
      end
      if (req_ready != '0) dut_grants++;

      quiet = (fl_q.size() == 0) && (exp_q.size() == 0);
      pop   = (exp_q.size() != 0) && out_ready;
      if (pop) void'(exp_q.pop_front());
      if (fl_q.size() != 0 && fl_q[0].due == cyc) begin
         f    = fl_q.pop_front();
         cw   = ham(f.nib);
         perr = 1'b0;
         if (flip_now) begin
            cw[0] = ~cw[0];
`ifdef ENC_ARB_PARITY_CHK_EN
            perr = 1'b1;
`endif
         end
         exp_q.push_back({cw, f.id, perr});
      end
      if (g >= 0) begin
         nib = req_data[g*4 +: 4];
         fl_q.push_back('{id: ID_W'(g), nib: nib, due: cyc + ENC_LAT + 1});
         m_ptr = (g + 1) % N_REQ;
         m_enc = nib;
      end else begin
         m_enc = 4'h0;
      end
      case (m_state)
         0: if (en) m_state = 1;
         1: if (!en) m_state = 2;
         default: begin
            if (en)         m_state = 1;
            else if (quiet) m_state = 0;
         end
      endcase
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_enc_data_o", 32'(enc_data_o), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_id", 32'(out_id), 32'd0);
      check("rst_out_perr", 32'(out_perr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      fl_q.delete();
      exp_q.delete();
      enc_hist.delete();
      m_state    = 0;
      m_ptr      = 0;
      m_enc      = '0;
      enc_data_i = '0;
      flip_arm   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      req_valid = '1;
      do_reset();

      // Single request from requester 0
      req_valid = '0;
      en        = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      req_data  = 16'h0005;
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      repeat (6) step();
      en = 1'b0;
      repeat (4) step();

      // All requesters continuously valid, consumer always ready
      en        = 1'b1;
      req_valid = '1;
      repeat (24) begin
         req_data = 16'($urandom());
         step();
      end

      // Consumer stalled from empty: exactly OUT_DEPTH transfers
      req_valid = '0;
      repeat (6) step();
      out_ready  = 1'b0;
      req_valid  = '1;
      dut_grants = 0;
      repeat (10) begin
         req_data = 16'($urandom());
         step();
      end
      check("stall_grants", 32'(dut_grants), 32'(OUT_DEPTH));
      out_ready = 1'b1;
      repeat (12) begin
         req_data = 16'($urandom());
         step();
      end

      // en dropped with two tags in flight
      req_valid = '0;
      repeat (6) step();
      req_valid = '1;
      repeat (2) begin
         req_data = 16'($urandom());
         step();
      end
      en = 1'b0;
      repeat (10) step();

      // Corrupt one returning codeword
      en        = 1'b1;
      req_valid = '1;
      flip_arm  = 1'b1;
      repeat (6) begin
         req_data = 16'($urandom());
         step();
      end
      req_valid = '0;
      repeat (8) step();

      // Random traffic
      repeat (300) begin
         req_valid = 4'($urandom());
         req_data  = 16'($urandom());
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) en = ~en;
         step();
      end

      // Reset in the middle of traffic
      en        = 1'b1;
      out_ready = 1'b0;
      req_valid = '1;
      repeat (5) begin
         req_data = 16'($urandom());
         step();
      end
      do_reset();
      out_ready = 1'b1;
      repeat (12) begin
         req_data = 16'($urandom());
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
